uno_hand: RTL
=============

# uno_hand

Per-player hand storage and draw sequencer for the UNO game datapath. Sits directly downstream of the card deck: it requests cards one at a time, captures each delivered 6-bit card (`[5:4]` colour, `[3:0]` value) into the target player's hand, and services card plays with in-place compaction. It also handles the opening deal (7 cards per player) and draw-two / draw-four penalties.

## Interface
Parameters:
- `NUM_PLAYERS`, 4: players; player index width is 2.
- `HAND_MAX`, 32: slots per hand; slot index width is 5, count width is 6.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset. Single clock domain; asynchronous, active-high reset.
- `i_deal_start`  in  1  pulse; clear all hands, then deal 7 cards to each player.
- `i_pen_valid`  in  1  pulse; penalty draw request.
- `i_pen_player`  in  2  player who receives the penalty cards.
- `i_pen_num`  in  3  number of cards to draw; legal values 1, 2, 4.
- `i_play_valid`  in  1  pulse; play request.
- `i_play_player`  in  2  player making the play.
- `i_play_idx`  in  5  slot index of the card to play.
- `i_top_card`  in  6  current discard top; used only with `UNO_HAND_PLAY_CHECK_EN`.
- `o_draw`  out  3  draw request to the deck; `3'b001` while requesting, otherwise 0.
- `i_drawn`  in  1  deck strobe; `i_card` is valid in this cycle.
- `i_card`  in  6  card delivered by the deck.
- `i_deck_done`  in  1  deck is idle and ready for the next request.
- `i_rd_player`  in  2  read port: player select.
- `i_rd_idx`  in  5  read port: slot select.
- `o_rd_card`  out  6  combinational read of the selected slot.
- `o_rd_count`  out  6  combinational card count of `i_rd_player`.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_play_card`  out  6  card removed by the last accepted play.
- `o_play_ack`  out  1  1-cycle pulse: play accepted.
- `o_play_nack`  out  1  1-cycle pulse: play rejected.
- `o_winner_valid`  out  1  1-cycle pulse: a hand reached 0 cards by a play.
- `o_winner`  out  2  player that emptied their hand.
- `o_overflow`  out  1  sticky: a card arrived for a full hand and was dropped.

## Operation
- States: IDLE, REQ, SETTLE, SHIFT.
- Request acceptance:
  - Requests are sampled only in IDLE; they are ignored while `o_busy` is high.
  - Priority: deal > penalty > play.
- Deal:
  - Clears all counts to 0 and sets remaining = 7*`NUM_PLAYERS`, target = player 0.
  - Target advances round-robin (0, 1, 2, 3, 0, …) after each captured card.
- Penalty:
  - Sets remaining = `i_pen_num` and target = `i_pen_player`.
  - `i_pen_num` of 0 is ignored; the block stays in IDLE.
- Draw loop:
  - REQ: drive `o_draw`=`3'b001`; hold until `i_drawn`.
  - On `i_drawn`: write `i_card` to the target hand at slot count, increment count, decrement remaining, go to SETTLE.
  - SETTLE: `o_draw`=0; wait for `i_deck_done`. Then go to REQ if remaining > 0, else IDLE.
- Full hand: if the target count equals `HAND_MAX`, the card is discarded, `o_overflow` sets, and the loop continues normally.
- Play:
  - Rejected if `i_play_idx` >= count; `o_play_nack` pulses and the hand is unchanged.
  - Otherwise the slot card is latched to `o_play_card`, count decrements, and `o_play_ack` pulses.
  - If the new count is 0, `o_winner_valid` pulses with `o_winner` = player.
  - If any cards remain above the played slot, go to SHIFT. SHIFT moves slot k+1 to slot k, one slot per cycle, from `i_play_idx` upward, for (old count − 1 − `i_play_idx`) cycles, then returns to IDLE.
- Slots at or above count hold don't-care data. `o_rd_card` is defined only for `i_rd_idx` < `o_rd_count`.

## Timing
- Reset values: state IDLE, all counts 0, all slots 0, all outputs 0 (including `o_overflow`).
- Reset asserted mid-operation aborts immediately: `o_draw` drops to 0 and the remaining/target registers clear.
- All outputs except `o_rd_card` and `o_rd_count` are registered.
- `o_draw` rises 1 cycle after the accepting edge.
- A captured card is visible on the read port the cycle after the `i_drawn` edge.
- `o_draw` falls in the cycle after `i_drawn`.
- `o_play_ack`, `o_play_nack` and `o_winner_valid` occur the cycle after the request edge.
- Compaction completes (old count − 1 − idx) cycles after ack; `o_busy` is high throughout.
- A play of the top slot takes 1 cycle of busy-free latency: the block returns to IDLE immediately.

## Configuration
- `UNO_HAND_PLAY_CHECK_EN` defined: a play is also rejected (nack) unless the card is legal against `i_top_card`. Legal means:
  - colour match, or
  - value match, or
  - card value 13 or 14.
- Not defined: no legality check. `i_top_card` is unused; nack is raised only for a bad index.

## Test plan
- Deal with the deck model answering each request after 3 cycles with cards 0, 1, 2, … → 28 requests; player p slot s = 4s+p; every `o_rd_count` = 7; `o_busy` falls.
- Penalty, player 2, num 4, count 7 → exactly 4 `o_draw` windows; count 11; slots 7–10 hold the delivered cards in order.
- Play player 1, idx 2, count 7 → ack; `o_play_card` = old slot 2; 4 SHIFT cycles; old slots 3–6 now at 2–5; count 6.
- Play idx 7 with count 7 → nack; hand unchanged. With the macro: top 0x03, card 0x16 → nack; card 0x1D → ack.
- Hand at count 1, play idx 0 → ack, `o_winner_valid` pulse with `o_winner` = player, 0 SHIFT cycles.
- Fill a hand to 32, then penalty 2 → both cards dropped; `o_overflow` = 1; count stays 32. Then assert reset during a REQ → `o_draw` = 0 and all counts 0 asynchronously.

Source files
------------

// File: rtl/uno_hand_if.sv
// uno_hand_if: request, deck-handshake and read-port bundle for uno_hand.
// slave is the hand block, master is the controller/deck side.
interface uno_hand_if #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned HAND_MAX    = 32
);
  localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned SW = $clog2(HAND_MAX);
  localparam int unsigned CW = $clog2(HAND_MAX + 1);

  logic          i_deal_start;
  logic          i_pen_valid;
  logic [PW-1:0] i_pen_player;
  logic [2:0]    i_pen_num;
  logic          i_play_valid;
  logic [PW-1:0] i_play_player;
  logic [SW-1:0] i_play_idx;
  logic [5:0]    i_top_card;
  logic [2:0]    o_draw;
  logic          i_drawn;
  logic [5:0]    i_card;
  logic          i_deck_done;
  logic [PW-1:0] i_rd_player;
  logic [SW-1:0] i_rd_idx;
  logic [5:0]    o_rd_card;
  logic [CW-1:0] o_rd_count;
  logic          o_busy;
  logic [5:0]    o_play_card;
  logic          o_play_ack;
  logic          o_play_nack;
  logic          o_winner_valid;
  logic [PW-1:0] o_winner;
  logic          o_overflow;

  modport slave (
    input  i_deal_start, i_pen_valid, i_pen_player, i_pen_num,
    input  i_play_valid, i_play_player, i_play_idx, i_top_card,
    input  i_drawn, i_card, i_deck_done, i_rd_player, i_rd_idx,
    output o_draw, o_rd_card, o_rd_count, o_busy, o_play_card,
    output o_play_ack, o_play_nack, o_winner_valid, o_winner, o_overflow
  );

  modport master (
    output i_deal_start, i_pen_valid, i_pen_player, i_pen_num,
    output i_play_valid, i_play_player, i_play_idx, i_top_card,
    output i_drawn, i_card, i_deck_done, i_rd_player, i_rd_idx,
    input  o_draw, o_rd_card, o_rd_count, o_busy, o_play_card,
    input  o_play_ack, o_play_nack, o_winner_valid, o_winner, o_overflow
  );
endinterface

// File: rtl/uno_hand.sv
// uno_hand: per-player hand storage, deck draw sequencer and play compaction.
// Optional play-legality check against the discard top: UNO_HAND_PLAY_CHECK_EN.
module uno_hand #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned HAND_MAX    = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  uno_hand_if.slave  bus
);
  localparam int unsigned PW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned SW         = $clog2(HAND_MAX);
  localparam int unsigned CW         = $clog2(HAND_MAX + 1);
  localparam int unsigned DEAL_CARDS = 7 * NUM_PLAYERS;
  localparam int unsigned RW         = $clog2(DEAL_CARDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SETTLE, S_SHIFT} state_t;

  state_t        state, state_next;
  logic [5:0]    hand  [NUM_PLAYERS][HAND_MAX];
  logic [CW-1:0] count [NUM_PLAYERS];
  logic [RW-1:0] remaining;
  logic [PW-1:0] target;
  logic          deal_mode;
  logic [PW-1:0] sh_player;
  logic [SW-1:0] sh_idx, sh_left;

  logic [2:0]    draw_r;
  logic          busy_r, ack_r, nack_r, win_v_r, overflow_r;
  logic [5:0]    play_card_r;
  logic [PW-1:0] winner_r;

  logic          deal_go, pen_go, play_req, play_ok, capture, card_legal;
  logic [CW-1:0] play_count, tgt_count, shift_len;
  logic [5:0]    play_slot;
  logic          tgt_full;

  assign play_count = count[bus.i_play_player];
  assign play_slot  = hand[bus.i_play_player][bus.i_play_idx];
  assign shift_len  = play_count - CW'(1) - CW'(bus.i_play_idx);
  assign tgt_count  = count[target];
  assign tgt_full   = (tgt_count == CW'(HAND_MAX));

`ifdef UNO_HAND_PLAY_CHECK_EN
  // Wild cards (values 13/14) are always playable.
  assign card_legal = (play_slot[5:4] == bus.i_top_card[5:4]) ||
                      (play_slot[3:0] == bus.i_top_card[3:0]) ||
                      (play_slot[3:0] == 4'd13) || (play_slot[3:0] == 4'd14);
`else
  logic unused_top;
  assign unused_top = ^bus.i_top_card;
  assign card_legal = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state and request decode; requests only sampled in IDLE.
  always_comb begin
    state_next = state;
    deal_go    = 1'b0;
    pen_go     = 1'b0;
    play_req   = 1'b0;
    play_ok    = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_deal_start) begin
          deal_go    = 1'b1;
          state_next = S_REQ;
        end else if (bus.i_pen_valid && (bus.i_pen_num != 3'd0)) begin
          pen_go     = 1'b1;
          state_next = S_REQ;
        end else if (bus.i_play_valid) begin
          play_req = 1'b1;
          play_ok  = (CW'(bus.i_play_idx) < play_count) && card_legal;
          if (play_ok && (shift_len != '0)) state_next = S_SHIFT;
        end
      end
      S_REQ: begin
        if (bus.i_drawn) begin
          capture    = 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (bus.i_deck_done) state_next = (remaining != '0) ? S_REQ : S_IDLE;
      end
      S_SHIFT: begin
        if (sh_left == SW'(1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sequencer bookkeeping and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      remaining   <= '0;
      target      <= '0;
      deal_mode   <= 1'b0;
      sh_player   <= '0;
      sh_idx      <= '0;
      sh_left     <= '0;
      draw_r      <= '0;
      busy_r      <= 1'b0;
      ack_r       <= 1'b0;
      nack_r      <= 1'b0;
      win_v_r     <= 1'b0;
      winner_r    <= '0;
      play_card_r <= '0;
      overflow_r  <= 1'b0;
    end else begin
      draw_r  <= (state_next == S_REQ) ? 3'b001 : 3'b000;
      busy_r  <= (state_next != S_IDLE);
      ack_r   <= play_ok;
      nack_r  <= play_req && !play_ok;
      win_v_r <= play_ok && (play_count == CW'(1));
      if (deal_go) begin
        remaining <= RW'(DEAL_CARDS);
        target    <= '0;
        deal_mode <= 1'b1;
      end else if (pen_go) begin
        remaining <= RW'(bus.i_pen_num);
        target    <= bus.i_pen_player;
        deal_mode <= 1'b0;
      end else if (capture) begin
        remaining <= remaining - RW'(1);
        if (deal_mode) target <= (target == PW'(NUM_PLAYERS - 1)) ? '0 : target + PW'(1);
        if (tgt_full) overflow_r <= 1'b1;
      end
      if (play_ok) begin
        play_card_r <= play_slot;
        sh_player   <= bus.i_play_player;
        sh_idx      <= bus.i_play_idx;
        sh_left     <= SW'(shift_len);
        if (play_count == CW'(1)) winner_r <= bus.i_play_player;
      end else if (state == S_SHIFT) begin
        sh_idx  <= sh_idx + SW'(1);
        sh_left <= sh_left - SW'(1);
      end
    end
  end

  // Hand storage: capture at slot count, compaction one slot per SHIFT cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        count[p] <= '0;
        for (int s = 0; s < HAND_MAX; s++) hand[p][s] <= '0;
      end
    end else if (deal_go) begin
      for (int p = 0; p < NUM_PLAYERS; p++) count[p] <= '0;
    end else if (capture && !tgt_full) begin
      hand[target][tgt_count[SW-1:0]] <= bus.i_card;
      count[target]                   <= tgt_count + CW'(1);
    end else if (play_ok) begin
      count[bus.i_play_player] <= play_count - CW'(1);
    end else if (state == S_SHIFT) begin
      hand[sh_player][sh_idx] <= hand[sh_player][sh_idx + SW'(1)];
    end
  end

  assign bus.o_draw         = draw_r;
  assign bus.o_busy         = busy_r;
  assign bus.o_play_ack     = ack_r;
  assign bus.o_play_nack    = nack_r;
  assign bus.o_winner_valid = win_v_r;
  assign bus.o_winner       = winner_r;
  assign bus.o_play_card    = play_card_r;
  assign bus.o_overflow     = overflow_r;
  assign bus.o_rd_card      = hand[bus.i_rd_player][bus.i_rd_idx];
  assign bus.o_rd_count     = count[bus.i_rd_player];

endmodule
